// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity modes and baud defaults.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK_WAIT
  } uart_rx_state_t;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  localparam int unsigned UART_CLKS_PER_BIT_115200 = 868;

endpackage

// File: rtl/uart_rx_stream_if.sv
// Receive-character stream: head of the RX FIFO with per-character error flags.
interface uart_rx_stream_if;

  logic [7:0] rd_data_o;
  logic       rd_frame_err_o;
  logic       rd_parity_err_o;
  logic       rd_valid_o;
  logic       rd_ready_i;

  modport master (
    output rd_data_o,
    output rd_frame_err_o,
    output rd_parity_err_o,
    output rd_valid_o,
    input  rd_ready_i
  );

  modport slave (
    input  rd_data_o,
    input  rd_frame_err_o,
    input  rd_parity_err_o,
    input  rd_valid_o,
    output rd_ready_i
  );

endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; pop on empty is ignored, push on full only lands with a pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_stream.sv
// UART receiver with centre sampling, parity/stop checking, glitch rejection and a FWFT receive FIFO.
module uart_rx_stream
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_115200,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = PAR_NONE,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_i,
  uart_rx_stream_if.master              rd,
  output logic                          overrun_o,
  input  logic                          clr_err_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          busy_o
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic          PAR_EXP = 1'(PARITY == PAR_ODD);

  uart_rx_state_t       state;
  logic                 rx_m;
  logic                 rx_s;
  logic [CW-1:0]        cnt;
  logic [2:0]           bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] data;
  logic                 par_err;
  logic                 frm_err;
  logic                 push_req;
  logic [DATA_BITS+1:0] push_word;
  logic [DATA_BITS+1:0] head;
  logic                 full;
  logic                 empty;
  logic [7:0]           data_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx_i;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      data      <= '0;
      par_err   <= 1'b0;
      frm_err   <= 1'b0;
      push_req  <= 1'b0;
      push_word <= '0;
      busy_o    <= 1'b0;
    end else begin
      push_req <= 1'b0;
      busy_o   <= (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= ST_START;
        end
        ST_START: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            if (rx_s) begin
              state <= ST_IDLE;
            end else begin
              state   <= ST_DATA;
              bit_idx <= '0;
              par_err <= 1'b0;
              frm_err <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt == FULL_M1) begin
            cnt  <= '0;
            // LSB arrives first, so after DATA_BITS right-shifts bit i sits at position i.
            data <= {rx_s, data[DATA_BITS-1:1]};
            if (bit_idx == LAST_BIT) begin
              state    <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
              stop_idx <= 1'b0;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_PARITY: begin
          if (cnt == FULL_M1) begin
            cnt     <= '0;
            par_err <= (((^data) ^ rx_s) != PAR_EXP);
            state   <= ST_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (cnt == FULL_M1) begin
            cnt <= '0;
            if (!rx_s) frm_err <= 1'b1;
            if (stop_idx == LAST_STOP) begin
              push_req  <= 1'b1;
              push_word <= {par_err, frm_err | ~rx_s, data};
              state     <= rx_s ? ST_IDLE : ST_BREAK_WAIT;
            end else begin
              stop_idx <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_BREAK_WAIT: begin
          if (rx_s) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .wdata (push_word),
    .pop   (rd.rd_ready_i),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count_o)
  );

  // Full implies valid, so a push is dropped exactly when the consumer is not popping.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_o <= 1'b0;
    end else if (push_req && full && !rd.rd_ready_i) begin
      overrun_o <= 1'b1;
    end else if (clr_err_i) begin
      overrun_o <= 1'b0;
    end
  end

  always_comb begin
    data_out = '0;
    if (!empty) data_out[DATA_BITS-1:0] = head[DATA_BITS-1:0];
  end

  assign rd.rd_valid_o      = ~empty;
  assign rd.rd_data_o       = data_out;
  assign rd.rd_frame_err_o  = ~empty & head[DATA_BITS];
  assign rd.rd_parity_err_o = ~empty & head[DATA_BITS+1];

endmodule
